// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, decode handshake and branch redirect.
// master = fetch controller, slave = memory/decode/branch environment.
interface fetch_if #(
    parameter int INSTRUCTION_SIZE      = 16,
    parameter int INSTRUCTION_ADDR_SIZE = 10
);
    logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr;
    logic [INSTRUCTION_SIZE-1:0]      imem_data;
    logic [INSTRUCTION_SIZE-1:0]      instr;
    logic [INSTRUCTION_ADDR_SIZE-1:0] instr_pc;
    logic                             instr_valid;
    logic                             instr_ready;
    logic                             branch_taken;
    logic [INSTRUCTION_ADDR_SIZE-1:0] branch_target;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid,
        input  imem_data, instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid,
        output imem_data, instr_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills a one-entry instruction buffer
// toward decode, handles branch redirects and stops on the HLT opcode.
module fetch_controller #(
    parameter int                         INSTRUCTION_SIZE      = 16,
    parameter int                         INSTRUCTION_ADDR_SIZE = 10,
    parameter logic [3:0]                 HLT_OPCODE            = 4'b0001,
    parameter logic [INSTRUCTION_ADDR_SIZE-1:0] RESET_PC        = '0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    fetch_if.master  bus,
    output logic     running,
    output logic     halted
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t                           state;
    logic [INSTRUCTION_ADDR_SIZE-1:0] pc;
    logic [INSTRUCTION_SIZE-1:0]      instr_q;
    logic [INSTRUCTION_ADDR_SIZE-1:0] instr_pc_q;
    logic                             instr_valid_q;
    logic                             running_q;
    logic                             halted_q;

    logic buf_free;
    logic accept;
    logic is_hlt;

    assign buf_free = !instr_valid_q || bus.instr_ready;
    assign accept   = instr_valid_q && bus.instr_ready;
    assign is_hlt   = (bus.imem_data[INSTRUCTION_SIZE-1 -: 4] == HLT_OPCODE);

    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign running         = running_q;
    assign halted          = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end

                RUN: begin
                    // Redirect wins over capture; the buffered word is dropped.
                    if (bus.branch_taken) begin
                        pc            <= bus.branch_target;
                        instr_valid_q <= 1'b0;
                    end else if (buf_free) begin
                        instr_q       <= bus.imem_data;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        if (is_hlt) begin
                            state <= DRAIN;
                        end else begin
                            pc <= pc + INSTRUCTION_ADDR_SIZE'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (bus.branch_taken) begin
                        pc            <= bus.branch_target;
                        instr_valid_q <= 1'b0;
                        state         <= RUN;
                    end else if (accept) begin
                        instr_valid_q <= 1'b0;
                        state         <= HALTED;
                        running_q     <= 1'b0;
                        halted_q      <= 1'b1;
                    end
                end

                HALTED: begin
                    if (start) begin
                        pc        <= RESET_PC;
                        state     <= RUN;
                        running_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    instr_valid_q <= 1'b0;
                    running_q     <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: halt, stall, branch, wrap and reset cases.
module tb_fetch_controller;

    localparam int IW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic running;
    logic halted;

    logic [IW-1:0] mem [1024];

    int n_checks = 0;
    int n_pass   = 0;

    fetch_if #(.INSTRUCTION_SIZE(IW), .INSTRUCTION_ADDR_SIZE(AW)) bus ();

    fetch_controller #(
        .INSTRUCTION_SIZE(IW),
        .INSTRUCTION_ADDR_SIZE(AW),
        .HLT_OPCODE(4'b0001),
        .RESET_PC('0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus.master),
        .running(running),
        .halted(halted)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h0000;
        mem[1]    = 16'h8101;
        mem[2]    = 16'h8201;
        mem[3]    = 16'h1000;
        mem[5]    = 16'h2345;
        mem[6]    = 16'h2346;
        mem[1023] = 16'h7777;

        rst = 1'b1; start = 1'b0;
        bus.instr_ready = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = '0;
        step(); step();
        check("rst_valid",   32'(bus.instr_valid), 32'd0);
        check("rst_running", 32'(running),         32'd0);
        check("rst_halted",  32'(halted),          32'd0);
        check("rst_addr",    32'(bus.imem_addr),   32'd0);
        check("rst_instr",   32'(bus.instr),       32'd0);
        check("rst_ipc",     32'(bus.instr_pc),    32'd0);

        // Straight-line program ending in HLT
        rst = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        check("start_running", 32'(running),         32'd1);
        check("start_novalid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("seq_valid", 32'(bus.instr_valid), 32'd1);
            check("seq_ipc",   32'(bus.instr_pc),    32'(i));
            check("seq_instr", 32'(bus.instr),       32'(mem[i]));
        end
        check("hlt_addr_hold", 32'(bus.imem_addr), 32'd3);
        step();
        check("halt_halted",  32'(halted),          32'd1);
        check("halt_running", 32'(running),         32'd0);
        check("halt_valid",   32'(bus.instr_valid), 32'd0);
        check("halt_addr",    32'(bus.imem_addr),   32'd3);

        // Branch ignored while halted
        bus.branch_taken = 1'b1; bus.branch_target = 10'd7;
        step(); bus.branch_taken = 1'b0;
        check("halt_br_halted", 32'(halted),        32'd1);
        check("halt_br_addr",   32'(bus.imem_addr), 32'd3);

        // Restart from HALTED
        start = 1'b1;
        step(); start = 1'b0;
        check("restart_running", 32'(running),       32'd1);
        check("restart_halted",  32'(halted),        32'd0);
        check("restart_addr",    32'(bus.imem_addr), 32'd0);
        step();
        check("restart_ipc0", 32'(bus.instr_pc),    32'd0);
        check("restart_v0",   32'(bus.instr_valid), 32'd1);
        step();
        check("stall_pre_ipc",   32'(bus.instr_pc), 32'd1);
        check("stall_pre_instr", 32'(bus.instr),    32'h8101);

        // Backpressure: hold for 3 cycles, with a start pulse that must be ignored
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            step();
            check("stall_instr", 32'(bus.instr),       32'h8101);
            check("stall_ipc",   32'(bus.instr_pc),    32'd1);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_pc",    32'(bus.imem_addr),   32'd2);
        end
        start = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        check("resume_ipc",   32'(bus.instr_pc), 32'd2);
        check("resume_instr", 32'(bus.instr),    32'h8201);
        step();
        check("drain_ipc",   32'(bus.instr_pc), 32'd3);
        check("drain_instr", 32'(bus.instr),    32'h1000);

        // Branch out of DRAIN with HLT still buffered
        bus.instr_ready = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 10'd1;
        step(); bus.branch_taken = 1'b0;
        check("drain_br_valid",  32'(bus.instr_valid), 32'd0);
        check("drain_br_halted", 32'(halted),          32'd0);
        check("drain_br_run",    32'(running),         32'd1);
        check("drain_br_addr",   32'(bus.imem_addr),   32'd1);
        step();
        check("drain_br_ipc",   32'(bus.instr_pc),    32'd1);
        check("drain_br_v",     32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        step();
        check("pre_br_ipc", 32'(bus.instr_pc), 32'd2);

        // Branch in RUN flushes the valid word even with ready high
        bus.branch_taken = 1'b1; bus.branch_target = 10'd5;
        step(); bus.branch_taken = 1'b0;
        check("run_br_valid", 32'(bus.instr_valid), 32'd0);
        check("run_br_addr",  32'(bus.imem_addr),   32'd5);
        step();
        check("run_br_ipc5",   32'(bus.instr_pc), 32'd5);
        check("run_br_instr5", 32'(bus.instr),    32'h2345);
        step();
        check("run_br_ipc6",   32'(bus.instr_pc), 32'd6);
        check("run_br_instr6", 32'(bus.instr),    32'h2346);

        // Synchronous reset mid-RUN
        rst = 1'b1;
        step(); rst = 1'b0;
        check("mid_rst_valid",   32'(bus.instr_valid), 32'd0);
        check("mid_rst_running", 32'(running),         32'd0);
        check("mid_rst_addr",    32'(bus.imem_addr),   32'd0);
        check("mid_rst_instr",   32'(bus.instr),       32'd0);
        step();
        check("idle_valid", 32'(bus.instr_valid), 32'd0);
        check("idle_addr",  32'(bus.imem_addr),   32'd0);

        // PC wrap at 1023
        start = 1'b1;
        step(); start = 1'b0;
        bus.branch_taken = 1'b1; bus.branch_target = 10'd1023;
        step(); bus.branch_taken = 1'b0;
        check("wrap_addr_top", 32'(bus.imem_addr), 32'd1023);
        step();
        check("wrap_ipc_top",   32'(bus.instr_pc),  32'd1023);
        check("wrap_instr_top", 32'(bus.instr),     32'h7777);
        check("wrap_addr_zero", 32'(bus.imem_addr), 32'd0);
        step();
        check("wrap_ipc_zero", 32'(bus.instr_pc),    32'd0);
        check("wrap_valid",    32'(bus.instr_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
